// File: rtl/fifo_skew_sched.sv
// Read scheduler for the per-row input FIFOs of the systolic array: issues
// diagonally skewed read enables, freezes the whole wavefront on any empty active row.
module fifo_skew_sched #(
    parameter int NUM_ROWS  = 4,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [NUM_ROWS-1:0]  fifo_empty,
    output logic [NUM_ROWS-1:0]  fifo_ren,
    output logic [NUM_ROWS-1:0]  valid_out,
    output logic                 busy,
    output logic                 done,
    output logic                 stall,
    output logic [1:0]           state_dbg
);

    // Counter is wide enough for len_q + NUM_ROWS - 2 at the largest len_q.
    localparam int TW = LEN_WIDTH + $clog2(NUM_ROWS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [TW-1:0]        t;
    logic [LEN_WIDTH-1:0] len_q;
    logic [TW-1:0]        len_ext;
    logic [TW-1:0]        last_t;
    logic [NUM_ROWS-1:0]  active;
    logic                 stall_c;

    assign len_ext = TW'(len_q);
    assign last_t  = len_ext + TW'(NUM_ROWS) - TW'(2);

    // Row r reads during r <= t < r + len_q, giving the diagonal wavefront.
    always_comb begin
        active = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            active[r] = (t >= TW'(r)) && (t < TW'(r) + len_ext);
        end
    end

    // One empty active row blocks every row so the skew between rows is kept.
    assign stall_c   = (state == RUN) && (|(active & fifo_empty));
    assign fifo_ren  = ((state == RUN) && !stall_c) ? active : '0;
    assign stall     = stall_c;
    assign busy      = (state != IDLE);
    assign done      = (state == DRAIN);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            len_q     <= '0;
            valid_out <= '0;
        end else begin
            // Mirrors the FIFOs' one-cycle read latency.
            valid_out <= abort ? '0 : fifo_ren;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        len_q <= len;
                        t     <= '0;
                        state <= (len == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        t     <= '0;
                    end else if (!stall_c) begin
                        t <= t + TW'(1);
                        if (t == last_t) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    t     <= '0;
                end
                default: begin
                    state <= IDLE;
                    t     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_skew_sched.sv
// Bench for fifo_skew_sched: per-job expected read-enable wavefronts are queued
// when a job is started and popped one per cycle as the scheduler runs.
module tb_fifo_skew_sched;

    localparam int N  = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [LW-1:0] len;
    logic [N-1:0]  fifo_empty;
    logic [N-1:0]  fifo_ren;
    logic [N-1:0]  valid_out;
    logic          busy;
    logic          done;
    logic          stall;
    logic [1:0]    state_dbg;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] trace_q[$];

    fifo_skew_sched #(.NUM_ROWS(N), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .len        (len),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .valid_out  (valid_out),
        .busy       (busy),
        .done       (done),
        .stall      (stall),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] wave(input int t, input int l);
        wave = '0;
        for (int r = 0; r < N; r++) wave[r] = (r <= t) && (t < r + l);
    endfunction

    // Drives one job from the start cycle (k=0) through a few idle cycles after done.
    // Cycle indices: abort_at / rst_at / restart_at are RUN-relative k values, 0 = unused.
    task automatic run_job(input int l, input int stall_row, input int stall_at, input int stall_n,
                           input int restart_at, input int abort_at, input int rst_at,
                           input int row3_empty_until);
        int run_len;
        int last_k;
        int ncyc;
        int ren_cnt[N];
        int done_cnt;
        bit killed;
        bit stall_k;
        logic [N-1:0] exp;
        logic [N-1:0] prev_exp;

        run_len  = (l == 0) ? 0 : l + N - 1;
        last_k   = run_len + stall_n + 1;
        ncyc     = last_k + 3;
        done_cnt = 0;
        killed   = 1'b0;
        for (int r = 0; r < N; r++) ren_cnt[r] = 0;
        exp_q.delete();
        trace_q.delete();
        for (int t = 0; t < run_len; t++) begin
            if (t == stall_at) for (int s = 0; s < stall_n; s++) exp_q.push_back('0);
            exp_q.push_back(wave(t, l));
        end

        start = 1'b1; len = LW'(l); abort = 1'b0; rst = 1'b0; fifo_empty = '0;
        @(negedge clk);
        check_eq("idle_ren", 32'(fifo_ren), 32'(0));
        check_eq("idle_busy", 32'(busy), 32'(0));
        prev_exp = '0;
        @(posedge clk); #1;
        start = 1'b0;

        for (int k = 1; k <= ncyc; k++) begin
            stall_k = !killed && (stall_n > 0) && (k > stall_at) && (k <= stall_at + stall_n);
            fifo_empty = '0;
            if (stall_k) fifo_empty[stall_row] = 1'b1;
            if (k <= row3_empty_until) fifo_empty[N-1] = 1'b1;
            start = (k == restart_at);
            if (start) len = LW'(7);
            abort = (k == abort_at);
            rst   = (k == rst_at);
            @(negedge clk);
            exp = (!killed && exp_q.size() > 0) ? exp_q.pop_front() : '0;
            trace_q.push_back(fifo_ren);
            check_eq("ren", 32'(fifo_ren), 32'(exp));
            check_eq("valid_out", 32'(valid_out), 32'(prev_exp));
            check_eq("stall", 32'(stall), 32'(stall_k));
            check_eq("busy", 32'(busy), 32'(!killed && k <= last_k));
            check_eq("done", 32'(done), 32'(!killed && k == last_k));
            if (killed) check_eq("state_idle", 32'(state_dbg), 32'(0));
            for (int r = 0; r < N; r++) ren_cnt[r] += int'(fifo_ren[r]);
            done_cnt += int'(done);
            if (k == abort_at || k == rst_at) begin
                killed   = 1'b1;
                prev_exp = '0;
            end else begin
                prev_exp = exp;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; fifo_empty = '0;

        if (killed) begin
            check_eq("done_count_killed", 32'(done_cnt), 32'(0));
        end else begin
            check_eq("done_count", 32'(done_cnt), 32'(1));
            for (int r = 0; r < N; r++) check_eq("ren_count", 32'(ren_cnt[r]), 32'(l));
        end
    endtask

    initial begin
        logic [N-1:0] golden[6];
        golden = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8};

        rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0; fifo_empty = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ren", 32'(fifo_ren), 32'(0));
        check_eq("rst_valid", 32'(valid_out), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        check_eq("rst_stall", 32'(stall), 32'(0));
        check_eq("rst_state", 32'(state_dbg), 32'(0));
        @(posedge clk); #1;

        // Basic len=3 job, also compared against the literal wavefront table.
        run_job(3, 2, -1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) check_eq("golden_ren", 32'(trace_q[i]), 32'(golden[i]));

        // Row 2 empty for two cycles at t=2.
        run_job(3, 2, 2, 2, 0, 0, 0, 0);
        // Zero-length job.
        run_job(0, 2, -1, 0, 0, 0, 0, 0);
        // start during RUN ignored; row 3 empty while still inactive must not stall.
        run_job(3, 2, -1, 0, 2, 0, 0, 3);
        // abort in the third RUN cycle, then a fresh job.
        run_job(3, 2, -1, 0, 0, 3, 0, 0);
        run_job(3, 2, -1, 0, 0, 0, 0, 0);
        // rst pulse mid-RUN.
        run_job(3, 2, -1, 0, 0, 0, 2, 0);
        // abort together with start in IDLE: job not accepted.
        start = 1'b1; abort = 1'b1; len = LW'(3);
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_start_busy", 32'(busy), 32'(0));
            check_eq("abort_start_ren", 32'(fifo_ren), 32'(0));
            check_eq("abort_start_state", 32'(state_dbg), 32'(0));
            @(posedge clk); #1;
        end
        // Longest job and shortest non-zero job.
        run_job(255, 1, 100, 1, 0, 0, 0, 0);
        run_job(1, 0, 0, 3, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
